// File: rtl/fw_local_intc_pkg.sv
// Local interrupt controller shared definitions:
// register map, access decode bundle and priority encoder.
package fw_local_intc_pkg;

  localparam logic [2:0] ADR_PENDING = 3'd0;
  localparam logic [2:0] ADR_MASK    = 3'd1;
  localparam logic [2:0] ADR_SWREQ   = 3'd2;
  localparam logic [2:0] ADR_EDGE    = 3'd3;
  localparam logic [2:0] ADR_CLAIM   = 3'd4;

  localparam int SWREQ_PEND_BIT = 31;
  localparam int CLAIM_W        = 5;

  typedef struct packed {
    logic wr_pend;
    logic wr_mask;
    logic wr_swreq;
    logic wr_edge;
    logic rd_claim;
  } acc_t;

  // Fixed priority, index 0 highest; returns id+1, 0 when empty.
  function automatic logic [CLAIM_W-1:0] prio_claim(
    input logic [31:0] v
  );
    logic [CLAIM_W-1:0] r;
    r = '0;
    for (int i = 30; i >= 0; i--) begin
      if (v[i]) r = CLAIM_W'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fw_intc_sync.sv
// Per-bit multi-flop synchroniser with async reset.
// STAGES=0 passes the input straight through.
module fw_intc_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clock ^ reset;
    assign q = d;
  end else begin : g_sync
    logic [STAGES-1:0][WIDTH-1:0] ff_q;

    // shift raw inputs through the flop chain
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ff_q <= '0;
      end else begin
        ff_q[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
          ff_q[i] <= ff_q[i-1];
        end
      end
    end

    assign q = ff_q[STAGES-1];
  end

endmodule

// File: rtl/fw_local_intc_pri.sv
// Local interrupt controller: level/edge sources,
// mask, software request, claim with fixed priority.
module fw_local_intc_pri
  import fw_local_intc_pkg::*;
#(
  parameter int               N_SRCS      = 8,
  parameter bit               EN_MASK     = 1'b1,
  parameter logic [N_SRCS-1:0] EDGE_RST   = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        r_adr,
  input  logic [31:0]       r_dat_w,
  output logic [31:0]       r_dat_r,
  input  logic              r_we,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [N_SRCS-1:0] src,
  output logic              irq
);

  logic [N_SRCS-1:0] s;
  logic [N_SRCS-1:0] prev_q;
  logic [N_SRCS-1:0] rise;
  logic [N_SRCS-1:0] edge_q;
  logic [N_SRCS-1:0] mask_q;
  logic [N_SRCS-1:0] edge_pend_q;
  logic [N_SRCS-1:0] edge_pend_d;
  logic [N_SRCS-1:0] pend;
  logic [N_SRCS-1:0] act;
  logic [N_SRCS-1:0] claim_oh;
  logic [N_SRCS-1:0] w1c_clr;
  logic [N_SRCS-1:0] edge_clr;
  logic [N_SRCS-1:0] claim_clr;
  logic [N_SRCS-1:0] wdat;
  logic [CLAIM_W-1:0] claim;
  logic              sw_req_q;
  logic              irq_q;
  acc_t              acc;
  logic              unused_ok;

  assign r_ready = 1'b1;
  assign irq     = irq_q;
  assign wdat    = r_dat_w[N_SRCS-1:0];

  fw_intc_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (N_SRCS)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (src),
    .q     (s)
  );

  // previous synchronised value, tracked in every mode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= s;
  end

  assign rise = s & ~prev_q;
  assign pend = (s & ~edge_q) | (edge_pend_q & edge_q);
  assign act  = pend & mask_q;

  assign claim    = prio_claim(32'(act));
  assign claim_oh = act & (~act + N_SRCS'(1));

  // decode the bus access into one-hot actions
  always_comb begin
    acc = '0;
    if (r_valid) begin
      unique case (1'b1)
        r_we  && (r_adr == ADR_PENDING): acc.wr_pend  = 1'b1;
        r_we  && (r_adr == ADR_MASK):    acc.wr_mask  = 1'b1;
        r_we  && (r_adr == ADR_SWREQ):   acc.wr_swreq = 1'b1;
        r_we  && (r_adr == ADR_EDGE):    acc.wr_edge  = 1'b1;
        !r_we && (r_adr == ADR_CLAIM):   acc.rd_claim = 1'b1;
        default: ;
      endcase
    end
  end

  // clears only touch edge sources; a same-cycle rise wins
  always_comb begin
    w1c_clr     = acc.wr_pend ? (wdat & edge_q) : '0;
    edge_clr    = acc.wr_edge ? ~wdat : '0;
    claim_clr   = acc.rd_claim ? (claim_oh & edge_q) : '0;
    edge_pend_d = (edge_pend_q & ~(w1c_clr | edge_clr | claim_clr))
                | (rise & edge_q);
  end

  // edge pending latch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) edge_pend_q <= '0;
    else       edge_pend_q <= edge_pend_d;
  end

  // trigger mode register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            edge_q <= EDGE_RST;
    else if (acc.wr_edge) edge_q <= wdat;
  end

  // software request bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             sw_req_q <= 1'b0;
    else if (acc.wr_swreq) sw_req_q <= r_dat_w[0];
  end

  if (EN_MASK) begin : g_mask
    // writable mask, everything masked out of reset
    always_ff @(posedge clock or posedge reset) begin
      if (reset)            mask_q <= '0;
      else if (acc.wr_mask) mask_q <= wdat;
    end
  end else begin : g_nomask
    assign mask_q = '1;
  end

  // registered interrupt request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= sw_req_q | (|act);
  end

  // combinational read mux, unused bits zero
  always_comb begin
    r_dat_r = '0;
    unique case (r_adr)
      ADR_PENDING: begin
        r_dat_r[N_SRCS-1:0]     = pend;
        r_dat_r[SWREQ_PEND_BIT] = sw_req_q;
      end
      ADR_MASK:  r_dat_r[N_SRCS-1:0]  = mask_q;
      ADR_SWREQ: r_dat_r[0]           = sw_req_q;
      ADR_EDGE:  r_dat_r[N_SRCS-1:0]  = edge_q;
      ADR_CLAIM: r_dat_r[CLAIM_W-1:0] = claim;
      default: ;
    endcase
  end

  assign unused_ok = ^{r_dat_w, acc.wr_mask};

endmodule
